// File: rtl/fft_link_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : fft_link_pkg
//  Brief    : Shared types and constants for the FFT host sample/result link.
//  Revision : 1.0
// ============================================================================
package fft_link_pkg;

  localparam int c_DEF_N      = 4;
  localparam int c_DEF_ADDR_W = 12;
  localparam int c_DEF_DATA_W = 32;
  localparam int c_CNT_W      = 12;
  localparam int c_AW_LAST    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/fft_stream_host_if.sv
`default_nettype none
// ============================================================================
//  Interface : fft_stream_host_if
//  Brief     : Sample (AR) and result (AW) channels between host and FFT core.
//  Revision  : 1.0
// ============================================================================
interface fft_stream_host_if
  import fft_link_pkg::*;
#(
  parameter int N      = c_DEF_N,
  parameter int DATA_W = c_DEF_DATA_W
);
  logic [c_CNT_W-1:0] SAMP_NUMBER;
  logic [DATA_W-1:0]  ARDATA;
  logic               ARVALID;
  logic               ARREADY;
  logic [N:0]         ARBURST;
  logic [DATA_W:0]    AWDATA;
  logic               AWVALID;
  logic               AWREADY;
  logic [N:0]         AWBURST;

  modport master (
    output SAMP_NUMBER, ARDATA, ARVALID, AWREADY,
    input  ARREADY, ARBURST, AWDATA, AWVALID, AWBURST
  );

  modport slave (
    input  SAMP_NUMBER, ARDATA, ARVALID, AWREADY,
    output ARREADY, ARBURST, AWDATA, AWVALID, AWBURST
  );
endinterface
`default_nettype wire

// File: rtl/fft_beat_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fft_beat_ram
//  Brief    : 1W/1R synchronous dual-port beat buffer, 1-cycle read latency.
//  Revision : 1.0
// ============================================================================
module fft_beat_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              n_Reset,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Output register holds when re is low so a parked read stays valid.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset)  r_q <= '0;
    else if (re)   r_q <= r_mem[raddr];
  end

  assign rdata = r_q;
endmodule
`default_nettype wire

// File: rtl/fft_stream_host.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stream_host
//  Brief    : Host peer of the FFT core: streams samples out in bursts and
//             collects results into a readable buffer.
//  Revision : 1.0
// ============================================================================
module fft_stream_host
  import fft_link_pkg::*;
#(
  parameter int N      = c_DEF_N,
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  wire logic               clk,
  input  wire logic               n_Reset,
  input  wire logic               start,
  input  wire logic [c_CNT_W-1:0] samp_number,
  input  wire logic               load_we,
  input  wire logic [ADDR_W-1:0]  load_addr,
  input  wire logic [DATA_W-1:0]  load_data,
  input  wire logic [ADDR_W-1:0]  res_addr,
  output logic      [DATA_W-1:0]  res_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  fft_stream_host_if.master       link
);
  state_t             r_state;
  logic [c_CNT_W-1:0] r_samp, r_rd_idx, r_sent, r_ridx;
  logic               r_rv, r_pf_vld, r_ar_valid, r_in_burst;
  logic               r_busy, r_done, r_err;
  logic [DATA_W-1:0]  r_pf_data, r_ar_data, w_ram_q;
  logic [N:0]         r_burst_len, r_bcnt, r_aw_bcnt;

  logic w_ar_fire, w_last_sent, w_burst_end, w_load_out, w_ram_hold, w_issue;
  logic w_aw_last, w_overflow, w_aw_ready, w_aw_fire, w_res_we;

  assign w_ar_fire   = r_ar_valid && link.ARREADY;
  assign w_last_sent = w_ar_fire && (r_sent == r_samp - 1'b1);
  assign w_burst_end = w_ar_fire && (r_bcnt == r_burst_len);
  // Output register refills from prefetch first, else from the RAM stage;
  // holding off on a burst-end handshake creates the single gap cycle.
  assign w_load_out  = (r_state == SEND) && (!r_ar_valid || w_ar_fire) &&
                       !w_burst_end && (r_pf_vld || r_rv);
  assign w_ram_hold  = r_rv && r_pf_vld && !w_load_out;
  assign w_issue     = (r_state == SEND) && (r_rd_idx < r_samp) && !w_ram_hold;

  assign w_aw_last   = link.AWDATA[c_AW_LAST];
  assign w_overflow  = (r_ridx == r_samp) && !w_aw_last;
  assign w_aw_ready  = (r_state == RECV) && !w_overflow;
  assign w_aw_fire   = link.AWVALID && w_aw_ready;
  assign w_res_we    = w_aw_fire && (r_ridx < r_samp);

  fft_beat_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_samp_ram (
    .clk(clk), .n_Reset(n_Reset),
    .we(load_we), .waddr(load_addr), .wdata(load_data),
    .re(w_issue), .raddr(r_rd_idx[ADDR_W-1:0]), .rdata(w_ram_q)
  );

  fft_beat_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res_ram (
    .clk(clk), .n_Reset(n_Reset),
    .we(w_res_we), .waddr(r_ridx[ADDR_W-1:0]), .wdata(link.AWDATA[DATA_W-1:0]),
    .re(1'b1), .raddr(res_addr), .rdata(res_data)
  );

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      r_state     <= IDLE;
      r_samp      <= '0;
      r_rd_idx    <= '0;
      r_sent      <= '0;
      r_ridx      <= '0;
      r_rv        <= 1'b0;
      r_pf_vld    <= 1'b0;
      r_pf_data   <= '0;
      r_ar_valid  <= 1'b0;
      r_ar_data   <= '0;
      r_in_burst  <= 1'b0;
      r_burst_len <= '0;
      r_bcnt      <= '0;
      r_aw_bcnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_samp     <= samp_number;
            r_err      <= 1'b0;
            r_rd_idx   <= '0;
            r_sent     <= '0;
            r_ridx     <= '0;
            r_bcnt     <= '0;
            r_aw_bcnt  <= '0;
            r_in_burst <= 1'b0;
            r_rv       <= 1'b0;
            r_pf_vld   <= 1'b0;
            if (samp_number == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= SEND;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (link.AWVALID) r_err <= 1'b1;
          if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
          r_rv <= w_issue || w_ram_hold;
          if (w_load_out) begin
            if (r_pf_vld) begin
              r_pf_vld  <= r_rv;
              r_pf_data <= w_ram_q;
            end
          end else if (r_rv && !r_pf_vld) begin
            r_pf_vld  <= 1'b1;
            r_pf_data <= w_ram_q;
          end
          if (w_load_out) begin
            r_ar_valid <= 1'b1;
            r_ar_data  <= r_pf_vld ? r_pf_data : w_ram_q;
            if (!r_in_burst) begin
              r_in_burst  <= 1'b1;
              r_burst_len <= link.ARBURST;
            end
          end else if (w_ar_fire) begin
            r_ar_valid <= 1'b0;
          end
          if (w_ar_fire) begin
            r_sent <= r_sent + 1'b1;
            r_bcnt <= w_burst_end ? '0 : r_bcnt + 1'b1;
            if (w_burst_end) r_in_burst <= 1'b0;
          end
          if (w_last_sent) r_state <= RECV;
        end
        RECV: begin
          if (link.AWVALID && w_overflow) r_err <= 1'b1;
          if (w_aw_fire) begin
            r_ridx    <= r_ridx + 1'b1;
            r_aw_bcnt <= (r_aw_bcnt == link.AWBURST) ? '0 : r_aw_bcnt + 1'b1;
            if (w_aw_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (r_ridx != r_samp - 1'b1) r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign link.SAMP_NUMBER = r_samp;
  assign link.ARDATA      = r_ar_data;
  assign link.ARVALID     = r_ar_valid;
  assign link.AWREADY     = w_aw_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fft_stream_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_stream_host
//  Brief    : Randomised scoreboard bench for fft_stream_host.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fft_stream_host;
  import fft_link_pkg::*;

  logic        clk = 1'b0, n_Reset = 1'b0, start = 1'b0, load_we = 1'b0;
  logic [11:0] samp_number = '0, load_addr = '0, res_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] res_data;
  logic        busy, done, err;

  fft_stream_host_if #(.N(4), .DATA_W(32)) lnk ();

  fft_stream_host #(.N(4), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .n_Reset(n_Reset), .start(start), .samp_number(samp_number),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .res_addr(res_addr), .res_data(res_data), .busy(busy), .done(done),
    .err(err), .link(lnk)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errs = 0;
  logic [31:0] mem_model [4096];
  logic [31:0] res_model [4096];
  logic [31:0] exp_ar [$];
  int          cur_n = 0, res_idx = 0, ar_pops = 0;
  bit          ar_first = 1'b0, burst_rand = 1'b0;
  int          ready_mode = 0;
  logic [4:0]  burst_fix = 5'd3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core-side ARREADY / ARBURST behaviour.
  initial begin
    lnk.ARREADY = 1'b0;
    lnk.ARBURST = '0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       lnk.ARREADY = 1'b1;
        1:       lnk.ARREADY = ~lnk.ARREADY;
        default: lnk.ARREADY = 1'($urandom_range(0, 1));
      endcase
      lnk.ARBURST = burst_rand ? 5'($urandom_range(0, 5)) : burst_fix;
    end
  end

  // Sample-channel monitor: data order, stall stability, burst gaps.
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [31:0] p_data = '0;
  logic [4:0] p_burst = '0;
  bit         in_burst = 1'b0;
  int         blen = 0, bcnt = 0, idle = 0;
  always @(negedge clk) begin
    if (!n_Reset) begin
      in_burst = 1'b0; idle = 0; p_valid = 1'b0; p_ready = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("ar_hold_valid", 64'(lnk.ARVALID), 64'(1'b1));
        chk("ar_hold_data", 64'(lnk.ARDATA), 64'(p_data));
      end
      if (in_burst) chk("ar_bubble", 64'(lnk.ARVALID), 64'(1'b1));
      else if (lnk.ARVALID) begin
        in_burst = 1'b1; blen = int'(p_burst); bcnt = 0;
        if (ar_first) ar_first = 1'b0;
        else chk("ar_gap_len", 64'(idle), 64'(1));
      end
      if (lnk.ARVALID && lnk.ARREADY) begin
        if (exp_ar.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL ar_extra_beat: got beat %0h expected none at %0t", lnk.ARDATA, $time);
        end else chk("ar_data", 64'(lnk.ARDATA), 64'(exp_ar.pop_front()));
        ar_pops++; bcnt++; idle = 0;
        if (bcnt == blen + 1 || exp_ar.size() == 0) in_burst = 1'b0;
      end else if (!lnk.ARVALID) idle++;
      p_valid = lnk.ARVALID; p_ready = lnk.ARREADY; p_data = lnk.ARDATA; p_burst = lnk.ARBURST;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_we = 1'b1; load_addr = 12'(a); load_data = d;
    mem_model[a] = d;
    tick(1);
    load_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    samp_number = 12'(n); start = 1'b1;
    cur_n = n; res_idx = 0; ar_first = 1'b1;
    for (int i = 0; i < n; i++) exp_ar.push_back(mem_model[i]);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_sent();
    for (int k = 0; k < 2000 && exp_ar.size() > 0; k++) @(negedge clk);
    if (exp_ar.size() > 0) begin
      n_checks++; n_errs++;
      $display("FAIL ar_timeout: got %0d beats pending expected 0", exp_ar.size());
      exp_ar.delete();
    end
    tick(1);
  endtask

  task automatic aw_beat(input bit last, input logic [31:0] d, input int lim, output bit acc);
    acc = 1'b0;
    lnk.AWVALID = 1'b1; lnk.AWDATA = {last, d};
    for (int k = 0; k < lim && !acc; k++) begin
      @(negedge clk); acc = lnk.AWREADY;
      @(posedge clk); #1;
    end
    lnk.AWVALID = 1'b0;
  endtask

  task automatic send_results(input int n, input int lastpos);
    bit acc;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      aw_beat(i == lastpos, d, 20, acc);
      chk("aw_accept", 64'(acc), 64'(1'b1));
      if (acc && res_idx < cur_n) begin
        res_model[res_idx] = d;
        res_idx++;
      end
      tick($urandom_range(0, 2));
    end
  endtask

  task automatic readback(input int n);
    for (int i = 0; i < n; i++) begin
      res_addr = 12'(i);
      @(posedge clk); @(negedge clk);
      chk("res_data", 64'(res_data), 64'(res_model[i]));
      #6;
    end
  endtask

  task automatic expect_flags(input logic e_busy, input logic e_done, input logic e_err);
    @(negedge clk);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("err", 64'(err), 64'(e_err));
    tick(1);
  endtask

  initial begin
    bit acc;
    int base;
    lnk.AWVALID = 1'b0; lnk.AWDATA = '0; lnk.AWBURST = 5'd3;
    tick(3);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_arvalid", 64'(lnk.ARVALID), 64'(0));
    chk("rst_awready", 64'(lnk.AWREADY), 64'(0));
    chk("rst_samp_number", 64'(lnk.SAMP_NUMBER), 64'(0));
    tick(1);
    n_Reset = 1'b1;
    tick(1);
    for (int i = 0; i < 32; i++) load(i, $urandom);

    // 8 samples in bursts of 4, then 8 results with last on the 8th.
    ready_mode = 0; burst_rand = 1'b0; burst_fix = 5'd3;
    do_start(8);
    @(negedge clk);
    chk("samp_number_reg", 64'(lnk.SAMP_NUMBER), 64'(8));
    wait_sent();
    @(negedge clk);
    chk("recv_awready", 64'(lnk.AWREADY), 64'(1));
    tick(1);
    samp_number = 12'd5; start = 1'b1; tick(1); start = 1'b0;
    @(negedge clk);
    chk("start_ignored", 64'(lnk.SAMP_NUMBER), 64'(8));
    tick(1);
    expect_flags(1'b1, 1'b0, 1'b0);
    send_results(8, 7);
    expect_flags(1'b0, 1'b1, 1'b0);
    readback(8);

    // Toggling ARREADY over 16 fresh samples.
    for (int i = 0; i < 16; i++) load(i, $urandom);
    ready_mode = 1; burst_fix = 5'd7;
    do_start(16);
    wait_sent();
    send_results(16, 15);
    expect_flags(1'b0, 1'b1, 1'b0);
    readback(16);

    // Random ready and per-burst random burst length.
    ready_mode = 2; burst_rand = 1'b1;
    do_start(20);
    wait_sent();
    send_results(20, 19);
    expect_flags(1'b0, 1'b1, 1'b0);
    readback(20);

    // Early last flag on the 5th of 8 results.
    ready_mode = 0; burst_rand = 1'b0; burst_fix = 5'd3;
    do_start(8);
    wait_sent();
    send_results(5, 4);
    expect_flags(1'b0, 1'b1, 1'b1);
    readback(5);

    // 9th result without last is refused; a following last completes.
    do_start(8);
    @(negedge clk);
    chk("err_cleared_on_start", 64'(err), 64'(0));
    wait_sent();
    send_results(8, -1);
    aw_beat(1'b0, $urandom, 3, acc);
    chk("overflow_refused", 64'(acc), 64'(0));
    expect_flags(1'b1, 1'b0, 1'b1);
    aw_beat(1'b1, $urandom, 20, acc);
    chk("overflow_last_accepted", 64'(acc), 64'(1));
    expect_flags(1'b0, 1'b1, 1'b1);
    readback(8);

    // Zero-length transform.
    do_start(0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_err", 64'(err), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_no_arvalid", 64'(lnk.ARVALID), 64'(0));
    end
    tick(1);

    // Result beat offered during SEND is ignored and flagged.
    do_start(4);
    lnk.AWVALID = 1'b1; lnk.AWDATA = {1'b1, 32'($urandom)};
    @(negedge clk);
    chk("send_awready_low", 64'(lnk.AWREADY), 64'(0));
    tick(1);
    lnk.AWVALID = 1'b0;
    wait_sent();
    send_results(4, 3);
    expect_flags(1'b0, 1'b1, 1'b1);
    readback(4);

    // Reset in the middle of SEND, then a clean restart from beat 0.
    burst_fix = 5'd31;
    do_start(8);
    base = ar_pops;
    for (int k = 0; k < 200 && ar_pops < base + 3; k++) @(posedge clk);
    #2 n_Reset = 1'b0;
    #1;
    chk("rst_mid_arvalid", 64'(lnk.ARVALID), 64'(0));
    chk("rst_mid_awready", 64'(lnk.AWREADY), 64'(0));
    exp_ar.delete();
    tick(2);
    expect_flags(1'b0, 1'b0, 1'b0);
    n_Reset = 1'b1;
    tick(1);
    do_start(8);
    wait_sent();
    send_results(8, 7);
    expect_flags(1'b0, 1'b1, 1'b0);
    readback(8);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
